// File: rtl/accel_hex_display.sv
// Signed 16-bit sample to 5-digit seven-segment display via sequential double-dabble.
// Define HEX_ZERO_BLANK_EN to blank leading zero digits above the ones digit.
module accel_hex_display #(
    parameter int UPDATE_CYCLES = 50_000_000
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    input  logic        iVALID,
    input  logic [15:0] iDATA,
    output logic [6:0]  oHEX0,
    output logic [6:0]  oHEX1,
    output logic [6:0]  oHEX2,
    output logic [6:0]  oHEX3,
    output logic [6:0]  oHEX4,
    output logic        oNEG,
    output logic        oBUSY,
    output logic        oUPD
);

`ifdef HEX_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_ZERO = 7'h7F;
`else
    localparam logic [6:0] LEAD_ZERO = 7'h40;
`endif

    typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

    state_t      state, state_next;
    logic [25:0] tick_cnt;
    logic        tick;
    logic [15:0] sample;
    logic [15:0] src;
    logic [15:0] mag;
    logic        neg_snap;
    logic [3:0]  bit_cnt;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic [34:0] seg_next;
    logic [34:0] seg_q;
    logic        neg_q;
    logic        commit;
    logic [3:0]  dig;
`ifdef HEX_ZERO_BLANK_EN
    logic        lead;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign tick = (tick_cnt == 26'(UPDATE_CYCLES - 1));
    // A sample arriving in the tick cycle takes precedence over the stored one
    assign src  = iVALID ? iDATA : sample;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (tick) state_next = CONV;
            CONV:    if (bit_cnt == 4'd15) state_next = ENC;
            ENC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oBUSY = 1'b0;
        unique case (state)
            CONV, ENC: oBUSY = 1'b1;
            default:   oBUSY = 1'b0;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] > 4'd4)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        seg_next = '0;
        dig      = 4'd0;
`ifdef HEX_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int i = 4; i >= 0; i--) begin
            dig = bcd[4*i +: 4];
            seg_next[7*i +: 7] = seg7(dig);
`ifdef HEX_ZERO_BLANK_EN
            lead = lead && (dig == 4'd0) && (i != 0);
            if (lead) seg_next[7*i +: 7] = 7'h7F;
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            tick_cnt <= '0;
            sample   <= '0;
            mag      <= '0;
            neg_snap <= 1'b0;
            bit_cnt  <= '0;
            bcd      <= '0;
            seg_q    <= '0;
            neg_q    <= 1'b0;
            commit   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
            if (iVALID) sample <= iDATA;
            commit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        mag      <= src[15] ? 16'(-src) : src;
                        neg_snap <= src[15];
                        bcd      <= '0;
                        bit_cnt  <= '0;
                    end
                end
                CONV: begin
                    bcd     <= {bcd_adj[18:0], mag[15]};
                    mag     <= {mag[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                ENC: begin
                    seg_q  <= seg_next;
                    neg_q  <= neg_snap && (bcd != 20'd0);
                    commit <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All display outputs move together, one edge after encoding
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oHEX0 <= 7'h40;
            oHEX1 <= LEAD_ZERO;
            oHEX2 <= LEAD_ZERO;
            oHEX3 <= LEAD_ZERO;
            oHEX4 <= LEAD_ZERO;
            oNEG  <= 1'b0;
            oUPD  <= 1'b0;
        end else begin
            oUPD <= commit;
            if (commit) begin
                oHEX0 <= seg_q[6:0];
                oHEX1 <= seg_q[13:7];
                oHEX2 <= seg_q[20:14];
                oHEX3 <= seg_q[27:21];
                oHEX4 <= seg_q[34:28];
                oNEG  <= neg_q;
            end
        end
    end

endmodule

// File: tb/tb_accel_hex_display.sv
// Directed bench for accel_hex_display with an expected-display scoreboard.
// Honors HEX_ZERO_BLANK_EN the same way the design does.
module tb_accel_hex_display;

    localparam int UC = 64;

`ifdef HEX_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;
    logic        neg, busy, upd;

    int vectors = 0;
    int miscompares = 0;
    int cyc;
    int upd_cyc;
    logic [35:0] sb[$];
    logic [35:0] rst_view;

    always #10 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    accel_hex_display #(.UPDATE_CYCLES(UC)) dut (
        .iCLK(clk), .iRSTN(rst_n), .iVALID(valid), .iDATA(data),
        .oHEX0(hex0), .oHEX1(hex1), .oHEX2(hex2), .oHEX3(hex3),
        .oHEX4(hex4), .oNEG(neg), .oBUSY(busy), .oUPD(upd)
    );

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t[10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic logic [35:0] model(input int v);
        int m, d;
        int p;
        logic [35:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            d = (m / p) % 10;
            r[7*i +: 7] = seg(d);
`ifdef HEX_ZERO_BLANK_EN
            if (i > 0 && m < p) r[7*i +: 7] = 7'h7F;
`endif
            p = p * 10;
        end
        r[35] = (v < 0);
        return r;
    endfunction

    function automatic logic [35:0] obs();
        return {neg, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic chk(input string tag, input logic [35:0] o,
                       input logic [35:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic drive(input int v);
        @(negedge clk);
        valid = 1'b1;
        data = 16'(v);
        sb.push_back(model(v));
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_phase(input string tag, input int p);
        int n = 0;
        while ((cyc % UC) != p && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((cyc % UC) != p) chk({tag, "_timeout"}, 36'(cyc % UC), 36'(p));
    endtask

    task automatic wait_upd(input string tag);
        int n = 0;
        logic [35:0] e;
        while (!upd && n < 200) begin
            @(negedge clk);
            n++;
        end
        upd_cyc = cyc;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (!upd) chk({tag, "_timeout"}, 36'(upd), 36'd1);
        else begin
            chk(tag, obs(), e);
            chk({tag, "_phase"}, 36'(cyc % UC), 36'd18);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 36'(upd), 36'd0);
    endtask

    initial begin
        rst_view = {1'b0, LZ, LZ, LZ, LZ, 7'h40};
        #35;
        chk("rst_disp", obs(), rst_view);
        chk("rst_busy_upd", {34'd0, busy, upd}, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sb.push_back(model(0));
        wait_upd("zero0");

        sb.push_back(model(0));
        wait_phase("ph1", 1);
        chk("busy_conv", 36'(busy), 36'd1);
        wait_phase("ph16", 16);
        chk("busy_enc", 36'(busy), 36'd1);
        chk("hold_enc", obs(), model(0));
        wait_phase("ph17", 17);
        chk("busy_idle", 36'(busy), 36'd0);
        wait_upd("zero1");

        drive(255);
        wait_upd("p255");
        drive(-250);
        wait_upd("n250");
        drive(-32768);
        wait_upd("min");
        drive(32767);
        wait_upd("max");

        drive(9);
        wait_upd("nine");
        wait_phase("ph63", 63);
        valid = 1'b1;
        data = 16'd5;
        sb.push_back(model(5));
        @(negedge clk);
        valid = 1'b0;
        wait_upd("coinc");

        drive(-7);
        wait_phase("ph8", 8);
        chk("busy_c8", 36'(busy), 36'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_disp", obs(), rst_view);
        chk("abort_busy_upd", {34'd0, busy, upd}, 36'd0);
        @(negedge clk);
        chk("abort_upd", 36'(upd), 36'd0);
        rst_n = 1'b1;
        sb.pop_front();
        sb.push_back(model(0));
        wait_upd("post_rst");
        chk("post_rst_cyc", 36'(upd_cyc), 36'(UC + 18));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
